// File: rtl/fc_mac_sequencer.sv
// Drives one fully-connected layer through the shared 2-stage MAC: operand fetch,
// MAC enable windowing, result capture and a valid/ready result hand-off.
//
// state | meaning
// IDLE  | waiting for start, MAC held cleared
// ISSUE | reading activation/weight pair i for neuron n (IN_LEN cycles)
// LAST  | last operand pair arrives from memory, MAC multiplies it
// DRAIN | MAC accumulates the last product
// CAPT  | MAC output sampled into res_data, MAC cleared
// OUT   | result held on res_valid until res_ready
module fc_mac_sequencer #(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 10,
  parameter int DAW     = $clog2(IN_LEN),
  parameter int WAW     = $clog2(IN_LEN * OUT_LEN),
  parameter int OIW     = (OUT_LEN > 1 ? $clog2(OUT_LEN) : 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  data_rd_en,
  output logic [DAW-1:0]        data_addr,
  output logic                  w_rd_en,
  output logic [WAW-1:0]        w_addr,
  output logic                  Cal_Valid,
  input  logic signed [31:0]    mac_dout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic signed [31:0]    res_data,
  output logic [OIW-1:0]        res_idx
);

  localparam logic [DAW-1:0] I_LAST = DAW'(IN_LEN - 1);
  localparam logic [OIW-1:0] N_LAST = OIW'(OUT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_LAST  = 3'd2,
    S_DRAIN = 3'd3,
    S_CAPT  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t         state, state_nx;
  logic [DAW-1:0] i_cnt, i_nx;
  logic [OIW-1:0] n_cnt, n_nx;
  logic [WAW-1:0] w_cnt, w_nx;
  logic           layer_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      i_cnt <= '0;
      n_cnt <= '0;
      w_cnt <= '0;
    end else begin
      state <= state_nx;
      i_cnt <= i_nx;
      n_cnt <= n_nx;
      w_cnt <= w_nx;
    end
  end

  // Weight address is a running counter: it steps through each neuron's row and
  // carries straight into the next row, returning to 0 only at layer end.
  always_comb begin
    state_nx  = state;
    i_nx      = i_cnt;
    n_nx      = n_cnt;
    w_nx      = w_cnt;
    layer_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ISSUE;
          i_nx     = '0;
          n_nx     = '0;
          w_nx     = '0;
        end
      end
      S_ISSUE: begin
        if (i_cnt == I_LAST) begin
          state_nx = S_LAST;
        end else begin
          i_nx = i_cnt + DAW'(1);
          w_nx = w_cnt + WAW'(1);
        end
      end
      S_LAST:  state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_CAPT;
      S_CAPT:  state_nx = S_OUT;
      S_OUT: begin
        if (res_ready) begin
          i_nx = '0;
          if (n_cnt == N_LAST) begin
            state_nx  = S_IDLE;
            n_nx      = '0;
            w_nx      = '0;
            layer_end = 1'b1;
          end else begin
            state_nx = S_ISSUE;
            n_nx     = n_cnt + OIW'(1);
            w_nx     = w_cnt + WAW'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Cal_Valid rises one cycle after the first read (when operand 0 lands) and
  // stays high through DRAIN, so the MAC sees exactly IN_LEN products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      data_rd_en <= 1'b0;
      w_rd_en    <= 1'b0;
      Cal_Valid  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_idx    <= '0;
    end else begin
      busy       <= (state_nx != S_IDLE);
      done       <= layer_end;
      data_rd_en <= (state_nx == S_ISSUE);
      w_rd_en    <= (state_nx == S_ISSUE);
      Cal_Valid  <= ((state == S_ISSUE) && (state_nx == S_ISSUE)) ||
                    (state_nx == S_LAST) || (state_nx == S_DRAIN);
      res_valid  <= (state_nx == S_OUT);
      if (state == S_CAPT) begin
        res_data <= mac_dout;
        res_idx  <= n_cnt;
      end
    end
  end

  assign data_addr = i_cnt;
  assign w_addr    = w_cnt;

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Directed bench for fc_mac_sequencer with IN_LEN=4, OUT_LEN=2, sync operand
// memories and a behavioural 2-stage MAC (product reg -> accumulator).
module tb_fc_mac_sequencer;

  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 2;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               busy;
  logic               done;
  logic               data_rd_en;
  logic [1:0]         data_addr;
  logic               w_rd_en;
  logic [2:0]         w_addr;
  logic               Cal_Valid;
  logic signed [31:0] mac_dout;
  logic               res_valid;
  logic               res_ready;
  logic signed [31:0] res_data;
  logic [0:0]         res_idx;

  int n_run  = 0;
  int n_fail = 0;

  fc_mac_sequencer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .data_rd_en(data_rd_en), .data_addr(data_addr), .w_rd_en(w_rd_en),
    .w_addr(w_addr), .Cal_Valid(Cal_Valid), .mac_dout(mac_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memories (1-cycle read latency) and MAC model
  logic signed [31:0] dmem [4];
  logic signed [31:0] wmem [8];
  logic signed [31:0] d_q, w_q, prod, acc;

  always @(posedge clk) begin
    if (data_rd_en) d_q <= dmem[data_addr];
    if (w_rd_en)    w_q <= wmem[w_addr];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= 0;
      acc  <= 0;
    end else if (!Cal_Valid) begin
      prod <= 0;
      acc  <= 0;
    end else begin
      prod <= d_q * w_q;
      acc  <= acc + prod;
    end
  end
  assign mac_dout = acc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_t1();
    for (int k = 0; k < 4; k++) dmem[k] = k + 1;
    for (int k = 0; k < 8; k++) wmem[k] = k + 1;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (data_rd_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic get_result(output logic signed [31:0] d, output logic [0:0] ix,
                            output bit ok);
    ok = 1'b0;
    d  = '0;
    ix = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (res_valid) begin
        ok = 1'b1;
        d  = res_data;
        ix = res_idx;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    load_t1();
    repeat (3) tick();
    n_run++;
    if ({busy, done, data_rd_en, w_rd_en, Cal_Valid, res_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, done, data_rd_en, w_rd_en, Cal_Valid, res_valid});
    end
    n_run++;
    if ({data_addr, w_addr, res_idx} !== 6'b0 || res_data !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%0d waddr=%0d idx=%0d data=%0d want all 0",
               data_addr, w_addr, res_idx, res_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // T1 + T6: full timeline, addresses and results with res_ready=1
  task automatic test_basic();
    bit ok;
    logic [4:0] exp_ctl;
    logic [1:0] exp_da;
    logic [2:0] exp_wa;
    bit exp_rd, exp_cv, exp_rv;
    load_t1();
    res_ready = 1'b1;
    pulse_start();
    wait_rd(ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_start: data_rd_en never asserted");
      return;
    end
    for (int c = 0; c <= 17; c++) begin
      exp_rd  = (c < 4) || (c >= 8 && c < 12);
      exp_cv  = (c >= 1 && c <= 5) || (c >= 9 && c <= 13);
      exp_rv  = (c == 7) || (c == 15);
      exp_ctl = {exp_rd, exp_rd, exp_cv, exp_rv, (c == 16)};
      n_run++;
      if ({data_rd_en, w_rd_en, Cal_Valid, res_valid, done} !== exp_ctl) begin
        n_fail++;
        $display("FAIL basic_ctl c=%0d: rd/wrd/cv/rv/done=%b want %b", c,
                 {data_rd_en, w_rd_en, Cal_Valid, res_valid, done}, exp_ctl);
      end
      n_run++;
      if (busy !== (c < 16)) begin
        n_fail++;
        $display("FAIL basic_busy c=%0d: got %b want %b", c, busy, (c < 16));
      end
      if (exp_rd) begin
        exp_da = (c < 4) ? 2'(c) : 2'(c - 8);
        exp_wa = (c < 4) ? 3'(c) : 3'(c - 4);
        n_run++;
        if (data_addr !== exp_da || w_addr !== exp_wa) begin
          n_fail++;
          $display("FAIL addr c=%0d: data_addr=%0d w_addr=%0d want %0d %0d",
                   c, data_addr, w_addr, exp_da, exp_wa);
        end
      end
      if (c == 7 || c == 15) begin
        n_run++;
        if (res_data !== ((c == 7) ? 32'sd30 : 32'sd70) || res_idx !== (c == 15)) begin
          n_fail++;
          $display("FAIL basic_res c=%0d: data=%0d idx=%0d want %0d %0d", c,
                   res_data, res_idx, (c == 7) ? 30 : 70, (c == 15));
        end
      end
      tick();
    end
  endtask

  // T2: negative products
  task automatic test_negative();
    bit ok;
    logic signed [31:0] d;
    logic [0:0] ix;
    for (int k = 0; k < 4; k++) dmem[k] = 5;
    for (int k = 0; k < 8; k++) wmem[k] = -1;
    res_ready = 1'b1;
    pulse_start();
    for (int r = 0; r < 2; r++) begin
      get_result(d, ix, ok);
      n_run++;
      if (!ok || d !== 32'hFFFF_FFEC || ix !== 1'(r)) begin
        n_fail++;
        $display("FAIL neg_res%0d: ok=%0d data=%h idx=%0d want FFFFFFEC %0d",
                 r, ok, d, ix, r);
      end
    end
    tick();
    n_run++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_done: got %b want 1", done);
    end
    tick();
  endtask

  // T3: backpressure in OUT
  task automatic test_backpressure();
    bit ok;
    logic signed [31:0] d;
    logic [0:0] ix;
    load_t1();
    res_ready = 1'b0;
    pulse_start();
    get_result(d, ix, ok);
    n_run++;
    if (!ok || d !== 32'sd30 || ix !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_res0: ok=%0d data=%0d idx=%0d want 30 0", ok, d, ix);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_run++;
      if ({res_valid, data_rd_en, w_rd_en, Cal_Valid} !== 4'b1000 ||
          res_data !== 32'sd30 || res_idx !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold k=%0d: rv/rd/wrd/cv=%b data=%0d idx=%0d want 1000 30 0",
                 k, {res_valid, data_rd_en, w_rd_en, Cal_Valid}, res_data, res_idx);
      end
    end
    res_ready = 1'b1;
    tick();
    n_run++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: res_valid=%b busy=%b want 0 1", res_valid, busy);
    end
    get_result(d, ix, ok);
    n_run++;
    if (!ok || d !== 32'sd70 || ix !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_res1: ok=%0d data=%0d idx=%0d want 70 1", ok, d, ix);
    end
    tick();
    n_run++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: got %b want 1", done);
    end
    tick();
  endtask

  // T4: start while busy is ignored
  task automatic test_start_busy();
    bit ok;
    logic signed [31:0] d0, d1;
    logic [0:0] i0, i1;
    load_t1();
    res_ready = 1'b0;
    pulse_start();
    wait_rd(ok);
    tick();
    tick();
    pulse_start();
    get_result(d0, i0, ok);
    pulse_start();
    res_ready = 1'b1;
    get_result(d1, i1, ok);
    n_run++;
    if (!ok || d0 !== 32'sd30 || i0 !== 1'b0 || d1 !== 32'sd70 || i1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_res: ok=%0d got %0d/%0d %0d/%0d want 30/0 70/1",
               ok, d0, i0, d1, i1);
    end
    tick();
    n_run++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_done: got %b want 1", done);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_run++;
      if (busy !== 1'b0 || data_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_idle k=%0d: busy=%b rd=%b want 0 0", k, busy, data_rd_en);
      end
    end
  endtask

  // T5: async reset mid-layer, then a clean rerun
  task automatic test_async_reset();
    bit ok;
    logic signed [31:0] d;
    logic [0:0] ix;
    load_t1();
    res_ready = 1'b1;
    pulse_start();
    get_result(d, ix, ok);
    wait_rd(ok);
    tick();
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({busy, done, data_rd_en, w_rd_en, Cal_Valid, res_valid} !== 6'b0 ||
        {data_addr, w_addr, res_idx} !== 6'b0 || res_data !== 32'sd0) begin
      n_fail++;
      $display("FAIL ar_clear: ctl=%b addr=%0d waddr=%0d idx=%0d data=%0d want all 0",
               {busy, done, data_rd_en, w_rd_en, Cal_Valid, res_valid},
               data_addr, w_addr, res_idx, res_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    for (int r = 0; r < 2; r++) begin
      get_result(d, ix, ok);
      n_run++;
      if (!ok || d !== ((r == 0) ? 32'sd30 : 32'sd70) || ix !== 1'(r)) begin
        n_fail++;
        $display("FAIL ar_res%0d: ok=%0d data=%0d idx=%0d want %0d %0d",
                 r, ok, d, ix, (r == 0) ? 30 : 70, r);
      end
    end
    tick();
    n_run++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_done: got %b want 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_start_busy();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
